// File: rtl/id_stage.sv
// id_stage: instruction decode stage of the 16-bit RISC pipeline.
//
// Splits the fetched instruction into fields, drives the register file read
// addresses, bypasses same-cycle writeback data, detects load-use hazards and
// holds the ID/EX pipeline register behind a valid/ready handshake.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   flush                          branch/jump taken in EX, kills ID contents
//   if_valid/if_ready              fetch handshake (if_instr, if_pc)
//   rf_read_addr1/2, rf_read_data1/2  register file read ports (combinational)
//   wb_en, wb_addr, wb_data        writeback port, as seen by the register file
//   ex_valid/ex_ready              execute handshake
//   ex_op..ex_pc                   decoded ID/EX register contents
module id_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          if_valid,
  output logic          if_ready,
  input  logic [DW-1:0] if_instr,
  input  logic [DW-1:0] if_pc,
  output logic [AW-1:0] rf_read_addr1,
  output logic [AW-1:0] rf_read_addr2,
  input  logic [DW-1:0] rf_read_data1,
  input  logic [DW-1:0] rf_read_data2,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          ex_valid,
  input  logic          ex_ready,
  output logic [3:0]    ex_op,
  output logic [AW-1:0] ex_rd,
  output logic [AW-1:0] ex_rs1,
  output logic [AW-1:0] ex_rs2,
  output logic          ex_wr_en,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic [DW-1:0] ex_opa,
  output logic [DW-1:0] ex_opb,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc
);

  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;

  function automatic logic signed [DW-1:0] sext6(input logic [5:0] f);
    return {{(DW-6){f[5]}}, f};
  endfunction

  function automatic logic signed [DW-1:0] sext12(input logic [11:0] f);
    return {{(DW-12){f[11]}}, f};
  endfunction

  // ---- p0: combinational decode of the fetched instruction ----
  logic [3:0]           op_p0;
  logic [AW-1:0]        rd_p0, rs1_p0, addr2_p0;
  logic                 use1_p0, use2_p0, wr_en_p0, mem_rd_p0, mem_wr_p0;
  logic signed [DW-1:0] imm_p0;
  logic [DW-1:0]        opa_p0, opb_p0;
  logic                 load_en, hazard;

  // ID/EX register contents
  logic                 vld_p1;
  logic [3:0]           op_p1;
  logic [AW-1:0]        rd_p1, rs1_p1, rs2_p1;
  logic                 wr_en_p1, mem_rd_p1, mem_wr_p1;
  logic [DW-1:0]        opa_p1, opb_p1, pc_p1;
  logic signed [DW-1:0] imm_p1;

  always_comb begin
    op_p0     = if_instr[15:12];
    rd_p0     = if_instr[9 +: AW];
    rs1_p0    = if_instr[6 +: AW];
    // SW and BEQ read their second operand from the rd field
    addr2_p0  = (op_p0 == OP_SW || op_p0 == OP_BEQ) ? if_instr[9 +: AW] : if_instr[3 +: AW];
    use1_p0   = (op_p0 <= OP_BEQ);
    use2_p0   = (op_p0 <= OP_SRL) || (op_p0 == OP_SW) || (op_p0 == OP_BEQ);
    wr_en_p0  = (op_p0 <= OP_LW);
    mem_rd_p0 = (op_p0 == OP_LW);
    mem_wr_p0 = (op_p0 == OP_SW);
    imm_p0    = '0;
    if (op_p0 > OP_SRL && op_p0 <= OP_BEQ) begin
      imm_p0 = sext6(if_instr[5:0]);
    end else if (op_p0 == OP_JMP) begin
      imm_p0 = sext12(if_instr[11:0]);
    end
    // register file writes on the edge, so a same-cycle write must be bypassed
    opa_p0 = (wb_en && wb_addr == rs1_p0)   ? wb_data : rf_read_data1;
    opb_p0 = (wb_en && wb_addr == addr2_p0) ? wb_data : rf_read_data2;
  end

  assign rf_read_addr1 = rs1_p0;
  assign rf_read_addr2 = addr2_p0;

  assign load_en  = !vld_p1 || ex_ready;
  assign hazard   = vld_p1 && mem_rd_p1 && if_valid &&
                    ((use1_p0 && rs1_p0 == rd_p1) || (use2_p0 && addr2_p0 == rd_p1));
  assign if_ready = load_en && !hazard && !flush;

  // ---- p1: ID/EX pipeline register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      op_p1     <= '0;
      rd_p1     <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      wr_en_p1  <= 1'b0;
      mem_rd_p1 <= 1'b0;
      mem_wr_p1 <= 1'b0;
      opa_p1    <= '0;
      opb_p1    <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_en) begin
      if (if_valid && !hazard) begin
        vld_p1    <= 1'b1;
        op_p1     <= op_p0;
        rd_p1     <= rd_p0;
        rs1_p1    <= rs1_p0;
        rs2_p1    <= addr2_p0;
        wr_en_p1  <= wr_en_p0;
        mem_rd_p1 <= mem_rd_p0;
        mem_wr_p1 <= mem_wr_p0;
        opa_p1    <= opa_p0;
        opb_p1    <= opb_p0;
        imm_p1    <= imm_p0;
        pc_p1     <= if_pc;
      end else begin
        // bubble: held fetch instruction retries next cycle
        vld_p1 <= 1'b0;
      end
    end
  end

  assign ex_valid  = vld_p1;
  assign ex_op     = op_p1;
  assign ex_rd     = rd_p1;
  assign ex_rs1    = rs1_p1;
  assign ex_rs2    = rs2_p1;
  assign ex_wr_en  = wr_en_p1;
  assign ex_mem_rd = mem_rd_p1;
  assign ex_mem_wr = mem_wr_p1;
  assign ex_opa    = opa_p1;
  assign ex_opb    = opb_p1;
  assign ex_imm    = imm_p1;
  assign ex_pc     = pc_p1;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk, rst_n, flush, if_valid, if_ready;
  logic [15:0] if_instr, if_pc;
  logic [2:0]  rf_read_addr1, rf_read_addr2;
  logic [15:0] rf_read_data1, rf_read_data2;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [3:0]  ex_op;
  logic [2:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_wr_en, ex_mem_rd, ex_mem_wr;
  logic [15:0] ex_opa, ex_opb, ex_imm, ex_pc;

  id_stage #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_opa(ex_opa), .ex_opb(ex_opb), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file stand-in: combinational reads, writes after the edge
  logic [15:0] rf [8];
  assign rf_read_data1 = rf[rf_read_addr1];
  assign rf_read_data2 = rf[rf_read_addr2];

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        wr, mrd, mwr;
    logic [15:0] opa, opb, imm, pc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // model of the ID/EX slot: what instruction (if any) is waiting for EX
  logic       m_v = 1'b0;
  logic       m_mrd = 1'b0;
  logic [2:0] m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic use1(input logic [15:0] ins);
    return ins[15:12] <= 4'd10;
  endfunction
  function automatic logic use2(input logic [15:0] ins);
    return ins[15:12] <= 4'd6 || ins[15:12] == 4'd9 || ins[15:12] == 4'd10;
  endfunction
  function automatic logic [2:0] src2(input logic [15:0] ins);
    return (ins[15:12] == 4'd9 || ins[15:12] == 4'd10) ? ins[11:9] : ins[5:3];
  endfunction

  function automatic exp_t ref_decode(input logic [15:0] ins, input logic [15:0] pc,
                                      input logic we, input logic [2:0] wa, input logic [15:0] wd);
    exp_t e;
    int   v;
    int   op;
    op    = int'(ins[15:12]);
    e.op  = ins[15:12];
    e.rd  = ins[11:9];
    e.rs1 = ins[8:6];
    e.rs2 = src2(ins);
    e.wr  = (op <= 8);
    e.mrd = (op == 8);
    e.mwr = (op == 9);
    e.opa = (we && wa == e.rs1) ? wd : rf[e.rs1];
    e.opb = (we && wa == e.rs2) ? wd : rf[e.rs2];
    e.pc  = pc;
    v = 0;
    if (op >= 7 && op <= 10) begin
      v = int'(ins[5:0]);
      if (v > 31) v -= 64;
    end else if (op == 11) begin
      v = int'(ins[11:0]);
      if (v > 2047) v -= 4096;
    end
    e.imm = 16'(v);
    return e;
  endfunction

  // monitor: every instruction EX consumes must match the next expected one
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready && !flush) begin
      exp_t a, e;
      a = '{op: ex_op, rd: ex_rd, rs1: ex_rs1, rs2: ex_rs2, wr: ex_wr_en, mrd: ex_mem_rd,
            mwr: ex_mem_wr, opa: ex_opa, opb: ex_opb, imm: ex_imm, pc: ex_pc};
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL ex_out: got %h, expected no instruction", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL ex_out: got %h, expected %h", a, e);
        end
      end
    end
  end

  // one cycle: apply inputs, predict handshake at negedge, update RF after the edge
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                       input logic rdy, input logic fl, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd);
    logic ld, hz;
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(negedge clk);
    ld = !m_v || rdy;
    hz = m_v && m_mrd && v &&
         ((use1(ins) && ins[8:6] == m_rd) || (use2(ins) && src2(ins) == m_rd));
    chk("if_ready", 32'(if_ready), 32'(ld && !hz && !fl));
    if (fl) begin
      if (m_v && q.size() > 0) q.delete(q.size() - 1);
      m_v = 1'b0;
    end else if (ld) begin
      if (v && !hz) begin
        q.push_back(ref_decode(ins, pc, we, wa, wd));
        m_v = 1'b1; m_mrd = (ins[15:12] == 4'd8); m_rd = ins[11:9];
      end else begin
        m_v = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (we) rf[wa] = wd;
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic rdy, input logic fl);
    drive(v, ins, pc, rdy, fl, 1'b0, 3'd0, 16'h0);
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [3:0] op;
    op = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
    return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 3'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'(i * 16'h1111);
    rst_n = 1'b0; flush = 0; if_valid = 0; if_instr = 0; if_pc = 0;
    ex_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    #1;
    chk("reset_valid", 32'(ex_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD r3,r1,r2
    rf[1] = 16'h0005; rf[2] = 16'h0007;
    step(1, 16'h0650, 16'h0100, 1, 0);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_op", 32'(ex_op), 32'd0);
    chk("add_rd", 32'(ex_rd), 32'd3);
    chk("add_opa", 32'(ex_opa), 32'h5);
    chk("add_opb", 32'(ex_opb), 32'h7);
    chk("add_wr", 32'(ex_wr_en), 32'd1);

    // asynchronous reset with a live ID/EX register
    rst_n = 1'b0; if_valid = 0;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_opa", 32'(ex_opa), 32'd0);
    chk("rst_pc", 32'(ex_pc), 32'd0);
    chk("rst_rd", 32'(ex_rd), 32'd0);
    m_v = 1'b0; q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // immediates
    step(1, 16'h747F, 16'h0002, 1, 0);
    chk("addi_imm", 32'(ex_imm), 32'hFFFF);
    step(1, 16'hB800, 16'h0004, 1, 0);
    chk("jmp_imm", 32'(ex_imm), 32'hF800);
    chk("jmp_wr", 32'(ex_wr_en), 32'd0);

    // writeback bypass: SUB r4,r1,r1 with r1 being written this cycle
    rf[1] = 16'h0000;
    drive(1, 16'h1848, 16'h0006, 1, 0, 1, 3'd1, 16'h1234);
    chk("byp_opa", 32'(ex_opa), 32'h1234);
    chk("byp_opb", 32'(ex_opb), 32'h1234);

    // load-use: LW r5,0(r1) then ADD r6,r5,r2
    step(1, 16'h8A40, 16'h0010, 1, 0);
    step(1, 16'h0D50, 16'h0012, 1, 0);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step(1, 16'h0D50, 16'h0012, 1, 0);
    chk("lu_issue_valid", 32'(ex_valid), 32'd1);
    chk("lu_issue_pc", 32'(ex_pc), 32'h0012);
    // LW r5 then ADD r6,r1,r2: independent, no stall
    step(1, 16'h8A40, 16'h0014, 1, 0);
    step(1, 16'h0C50, 16'h0016, 1, 0);
    chk("nolu_pc", 32'(ex_pc), 32'h0016);

    // backpressure
    step(1, 16'h0650, 16'h0020, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h747F, 16'h0024, 0, 0);
      chk("bp_hold_pc", 32'(ex_pc), 32'h0020);
      chk("bp_hold_valid", 32'(ex_valid), 32'd1);
    end
    step(1, 16'h747F, 16'h0024, 1, 0);
    chk("bp_next_pc", 32'(ex_pc), 32'h0024);

    // flush with valid ID/EX and valid fetch
    step(1, 16'h0650, 16'h0028, 0, 1);
    chk("flush_valid", 32'(ex_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 9) < 8), rnd_instr(), 16'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
            1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
    end

    for (int i = 0; i < 3; i++) step(0, 16'h0, 16'h0, 1, 0);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
